staff_player: RTL and testbench

- Parametrised successor to the staff snapshot/playback path.
- Captures a voices × steps grid of note entries from the staff recogniser, then steps through it at a fixed tick rate.
- Emits proper MIDI note-on/note-off events over a valid/ready handshake into the MIDI merge/synth path.
- Adds looping, clean stop (all-notes-off drain), rest handling and back-pressure.

---
 rtl/staff_player.sv | 261 ++++++++++++++++++++++++++
 tb/tb_staff_player.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/staff_player.sv
// staff_player
//   Snapshots a voices x steps grid of note entries from the staff recogniser
//   and plays it back one step per tick, emitting MIDI note-on / note-off
//   events over a valid/ready handshake. Supports looping, rests, clean stop
//   (note-off drain of every sounding voice) and downstream back-pressure.
//
// Ports
//   clk_in, rst_in     single clock; synchronous active-high reset
//   load_in            pulse: snapshot note_memory_in (honoured only in IDLE)
//   note_memory_in     flattened grid, entry(v,s) at (s*NUM_VOICES+v)*ENTRY_WIDTH
//   play_in            level: run playback while high
//   loop_in            level: at the last step wrap to step 0 instead of stopping
//   midi_ready_in      downstream accepts the presented event
//   midi_valid_out     event present (held with its payload until accepted)
//   midi_note_out      note number, bit 7 always 0
//   midi_velocity_out  VELOCITY on note-on, 0 on note-off
//   midi_status_out    1 = note-on, 0 = note-off
//   step_out           current step index
//   busy_out           high whenever not IDLE
//   loaded_out         a grid has been captured since reset
//
// Optional build macro STAFF_PLAYER_TEMPO_EN adds step_cycles_in[31:0], the
// step period sampled on entry to WAIT (0 behaves as 1). Without it the
// period is the STEP_CYCLES parameter.
module staff_player #(
    parameter int NUM_VOICES  = 5,
    parameter int NUM_STEPS   = 64,
    parameter int ENTRY_WIDTH = 12,
    parameter int STEP_CYCLES = 12_500_000,
    parameter int VELOCITY    = 127
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      load_in,
    input  logic [NUM_VOICES*NUM_STEPS*ENTRY_WIDTH-1:0] note_memory_in,
    input  logic                                      play_in,
    input  logic                                      loop_in,
    input  logic                                      midi_ready_in,
`ifdef STAFF_PLAYER_TEMPO_EN
    input  logic [31:0]                               step_cycles_in,
`endif
    output logic                                      midi_valid_out,
    output logic [7:0]                                midi_note_out,
    output logic [7:0]                                midi_velocity_out,
    output logic                                      midi_status_out,
    output logic [$clog2(NUM_STEPS)-1:0]              step_out,
    output logic                                      busy_out,
    output logic                                      loaded_out
);

    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
    localparam logic [7:0] VEL_ON = {1'b0, 7'(VELOCITY)};

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DRAIN} state_t;

    state_t state, state_next;

    logic [ENTRY_WIDTH-1:0] grid_in [NUM_STEPS][NUM_VOICES];
    logic [ENTRY_WIDTH-1:0] grid    [NUM_STEPS][NUM_VOICES];
    logic                   do_load;

    logic                   loaded, loaded_next;
    logic [STEP_W-1:0]      step, step_next;
    logic [VOICE_W-1:0]     voice, voice_next;
    logic [31:0]            timer, timer_next, reload;
    logic [NUM_VOICES-1:0]  sounding, sounding_next;
    logic [6:0]             held_note [NUM_VOICES];
    logic [6:0]             held_note_next [NUM_VOICES];
    logic                   evt_valid, evt_valid_next;
    logic [6:0]             evt_note, evt_note_next;
    logic                   evt_on, evt_on_next;
    logic [7:0]             evt_vel;

    logic [ENTRY_WIDTH-1:0] entry;
    logic [3:0]             octave, kind;
    logic                   is_rest;
    logic [7:0]             note_sum;
    logic [6:0]             cur_note;

    // Unflatten the input bus so the snapshot can be addressed as [step][voice].
    for (genvar s = 0; s < NUM_STEPS; s++) begin : g_step
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            assign grid_in[s][v] = note_memory_in[(s*NUM_VOICES+v)*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
    end

    // Decode the entry under the scan pointer. 12*15+11 is the largest
    // non-rest value and still fits 8 bits, so saturation only clamps to 127.
    assign entry    = grid[step][voice];
    assign octave   = entry[3:0];
    assign kind     = entry[7:4];
    assign is_rest  = (kind >= 4'd12);
    assign note_sum = {4'b0, octave} * 8'd12 + {4'b0, kind};
    assign cur_note = (note_sum > 8'd127) ? 7'd127 : note_sum[6:0];

    // Bits above the octave/kind fields carry nothing for playback.
    if (ENTRY_WIDTH > 8) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^entry[ENTRY_WIDTH-1:8];
    end

    // Step period for the coming WAIT; with the tempo input a zero request is
    // treated as a single-cycle step.
`ifdef STAFF_PLAYER_TEMPO_EN
    assign reload = (step_cycles_in == 32'd0) ? 32'd0 : step_cycles_in - 32'd1;
`else
    assign reload = 32'(STEP_CYCLES - 1);
`endif

    // Snapshot store. Left out of reset on purpose: its content means nothing
    // until loaded_out is set, and skipping reset keeps it plain RAM-like flops.
    always_ff @(posedge clk_in) begin
        if (do_load) begin
            grid <= grid_in;
        end
    end

    // State and datapath registers. Reset returns everything to silence
    // without emitting note-offs since the downstream path resets too.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            loaded    <= 1'b0;
            step      <= '0;
            voice     <= '0;
            timer     <= '0;
            sounding  <= '0;
            held_note <= '{default: '0};
            evt_valid <= 1'b0;
            evt_note  <= '0;
            evt_on    <= 1'b0;
            evt_vel   <= '0;
        end else begin
            state     <= state_next;
            loaded    <= loaded_next;
            step      <= step_next;
            voice     <= voice_next;
            timer     <= timer_next;
            sounding  <= sounding_next;
            held_note <= held_note_next;
            evt_valid <= evt_valid_next;
            evt_note  <= evt_note_next;
            evt_on    <= evt_on_next;
            evt_vel   <= evt_on_next ? VEL_ON : 8'd0;
        end
    end

    // Next-state logic. SCAN and DRAIN only act when no event is pending, and
    // each visit does at most one thing for the current voice: a voice that
    // needs note-off then note-on is visited twice, and the pointer moves on
    // only when the voice has nothing left to emit. Transfers clear the
    // pending event, so a new one can appear no sooner than one cycle later.
    always_comb begin
        state_next     = state;
        loaded_next    = loaded;
        step_next      = step;
        voice_next     = voice;
        timer_next     = timer;
        sounding_next  = sounding;
        held_note_next = held_note;
        evt_valid_next = evt_valid;
        evt_note_next  = evt_note;
        evt_on_next    = evt_on;
        do_load        = 1'b0;

        if (evt_valid && midi_ready_in) begin
            evt_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (load_in) begin
                    do_load     = 1'b1;
                    loaded_next = 1'b1;
                end else if (play_in && loaded) begin
                    step_next  = '0;
                    voice_next = '0;
                    state_next = SCAN;
                end
            end

            SCAN: begin
                if (!evt_valid) begin
                    if (!play_in) begin
                        voice_next = '0;
                        state_next = DRAIN;
                    end else if (sounding[voice] && (is_rest || cur_note != held_note[voice])) begin
                        evt_valid_next       = 1'b1;
                        evt_note_next        = held_note[voice];
                        evt_on_next          = 1'b0;
                        sounding_next[voice] = 1'b0;
                    end else if (!is_rest && !sounding[voice]) begin
                        evt_valid_next        = 1'b1;
                        evt_note_next         = cur_note;
                        evt_on_next           = 1'b1;
                        sounding_next[voice]  = 1'b1;
                        held_note_next[voice] = cur_note;
                    end else if (voice == LAST_VOICE) begin
                        timer_next = reload;
                        state_next = WAIT;
                    end else begin
                        voice_next = voice + 1'b1;
                    end
                end
            end

            WAIT: begin
                if (!play_in) begin
                    voice_next = '0;
                    state_next = DRAIN;
                end else if (timer == 32'd0) begin
                    voice_next = '0;
                    if (step != LAST_STEP) begin
                        step_next  = step + 1'b1;
                        state_next = SCAN;
                    end else if (loop_in) begin
                        step_next  = '0;
                        state_next = SCAN;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    timer_next = timer - 32'd1;
                end
            end

            DRAIN: begin
                if (!evt_valid) begin
                    if (sounding[voice]) begin
                        evt_valid_next       = 1'b1;
                        evt_note_next        = held_note[voice];
                        evt_on_next          = 1'b0;
                        sounding_next[voice] = 1'b0;
                    end else if (voice == LAST_VOICE) begin
                        step_next  = '0;
                        voice_next = '0;
                        state_next = IDLE;
                    end else begin
                        voice_next = voice + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign midi_valid_out    = evt_valid;
    assign midi_note_out     = {1'b0, evt_note};
    assign midi_velocity_out = evt_vel;
    assign midi_status_out   = evt_on;
    assign step_out          = step;
    assign busy_out          = (state != IDLE);
    assign loaded_out        = loaded;

endmodule

// File: tb/tb_staff_player.sv
// tb_staff_player
//   Directed self-checking bench for staff_player with a 2-voice, 4-step grid
//   and an 8-cycle step. Every accepted MIDI event is logged by a monitor and
//   compared against hand-derived event lists.
module tb_staff_player;

    localparam int NV = 2;
    localparam int NS = 4;
    localparam int EW = 12;
    localparam int SC = 8;

    localparam logic [EW-1:0] REST   = 12'h0C0;
    localparam logic [EW-1:0] C4     = 12'h004;
    localparam logic [EW-1:0] C4_PAD = 12'hA04;
    localparam logic [EW-1:0] D4     = 12'h024;
    localparam logic [EW-1:0] C5     = 12'h005;
    localparam logic [EW-1:0] TOP    = 12'h0BF;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            load_in;
    logic            play_in;
    logic            loop_in;
    logic            midi_ready_in;
    logic [NV*NS*EW-1:0] note_memory_in;
    logic [EW-1:0]   ent [NS][NV];
    logic            midi_valid_out;
    logic [7:0]      midi_note_out;
    logic [7:0]      midi_velocity_out;
    logic            midi_status_out;
    logic [1:0]      step_out;
    logic            busy_out;
    logic            loaded_out;

    int              compareCount = 0;
    int              mismatchCount = 0;
    logic [16:0]     evq [$];

    staff_player #(
        .NUM_VOICES (NV),
        .NUM_STEPS  (NS),
        .ENTRY_WIDTH(EW),
        .STEP_CYCLES(SC),
        .VELOCITY   (127)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .load_in          (load_in),
        .note_memory_in   (note_memory_in),
        .play_in          (play_in),
        .loop_in          (loop_in),
        .midi_ready_in    (midi_ready_in),
`ifdef STAFF_PLAYER_TEMPO_EN
        .step_cycles_in   (32'(SC)),
`endif
        .midi_valid_out   (midi_valid_out),
        .midi_note_out    (midi_note_out),
        .midi_velocity_out(midi_velocity_out),
        .midi_status_out  (midi_status_out),
        .step_out         (step_out),
        .busy_out         (busy_out),
        .loaded_out       (loaded_out)
    );

    // 100 MHz-style clock, period 10.
    always #5 clk_in = ~clk_in;

    // Pack the bench-side grid onto the flattened bus.
    for (genvar s = 0; s < NS; s++) begin : g_s
        for (genvar v = 0; v < NV; v++) begin : g_v
            assign note_memory_in[(s*NV+v)*EW +: EW] = ent[s][v];
        end
    end

    // Log every handshake transfer mid-cycle, well away from the active edge.
    always @(negedge clk_in) begin
        if (!rst_in && midi_valid_out && midi_ready_in) begin
            evq.push_back({midi_status_out, midi_velocity_out, midi_note_out});
        end
    end

    // Hard stop in case something wedges despite the bounded loops.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [16:0] ev(input logic on, input logic [7:0] note);
        return {on, on ? 8'd127 : 8'd0, note};
    endfunction

    task automatic applyStimulus(input logic ld, input logic pl, input logic lp, input logic rdy);
        load_in       = ld;
        play_in       = pl;
        loop_in       = lp;
        midi_ready_in = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkEvent(input string tag, input int idx, input logic on, input logic [7:0] note);
        logic [31:0] got;
        got = (idx < evq.size()) ? 32'(evq[idx]) : 32'hDEAD_BEEF;
        checkOutput(tag, got, 32'(ev(on, note)));
    endtask

    task automatic resetDut();
        rst_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rst_in = 1'b0;
        evq.delete();
    endtask

    task automatic setVoice0(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                             input logic [EW-1:0] e2, input logic [EW-1:0] e3);
        ent[0][0] = e0;
        ent[1][0] = e1;
        ent[2][0] = e2;
        ent[3][0] = e3;
        for (int s = 0; s < NS; s++) ent[s][1] = REST;
    endtask

    task automatic loadGrid();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic runToIdle(input logic lp, input int budget);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b1, lp, 1'b1);
            n++;
        end while (busy_out && n < budget);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("run_idle", 32'(busy_out), 32'd0);
    endtask

    task automatic stopAndDrain(input int budget);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end while (busy_out && n < budget);
        checkOutput("drain_idle", 32'(busy_out), 32'd0);
        checkOutput("drain_step0", 32'(step_out), 32'd0);
    endtask

    task automatic waitStep(input logic lp, input logic [1:0] target, input string tag);
        int n;
        n = 0;
        while (step_out != target && n < 200) begin
            applyStimulus(1'b0, 1'b1, lp, 1'b1);
            n++;
        end
        checkOutput(tag, 32'(step_out), 32'(target));
    endtask

    initial begin
        int n;
        int d;
        rst_in        = 1'b0;
        load_in       = 1'b0;
        play_in       = 1'b0;
        loop_in       = 1'b0;
        midi_ready_in = 1'b1;
        setVoice0(C4, C4, C4, C4);

        // Reset values.
        resetDut();
        checkOutput("rst_valid", 32'(midi_valid_out), 32'd0);
        checkOutput("rst_note", 32'(midi_note_out), 32'd0);
        checkOutput("rst_vel", 32'(midi_velocity_out), 32'd0);
        checkOutput("rst_status", 32'(midi_status_out), 32'd0);
        checkOutput("rst_step", 32'(step_out), 32'd0);
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        checkOutput("rst_loaded", 32'(loaded_out), 32'd0);

        // Play requested before any load must not start.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("noload_busy", 32'(busy_out), 32'd0);

        // Sustained C4 across all steps: one note-on, one note-off.
        $display("[TB] sustained C4, no loop");
        loadGrid();
        checkOutput("t1_loaded", 32'(loaded_out), 32'd1);
        waitStep(1'b0, 2'd1, "t1_reach_step1");
        d = 0;
        while (step_out == 2'd1 && d < 100) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            d++;
        end
        checkOutput("t1_step1_len", 32'(d), 32'(NV + SC));
        runToIdle(1'b0, 200);
        checkOutput("t1_count", 32'(evq.size()), 32'd2);
        checkEvent("t1_ev0", 0, 1'b1, 8'd48);
        checkEvent("t1_ev1", 1, 1'b0, 8'd48);
        checkOutput("t1_step", 32'(step_out), 32'd0);

        // Note changes and a rest; upper entry bits must be ignored.
        $display("[TB] 48, 50, rest, 50");
        setVoice0(C4_PAD, D4, REST, D4);
        loadGrid();
        evq.delete();
        runToIdle(1'b0, 300);
        checkOutput("t2_count", 32'(evq.size()), 32'd6);
        checkEvent("t2_ev0", 0, 1'b1, 8'd48);
        checkEvent("t2_ev1", 1, 1'b0, 8'd48);
        checkEvent("t2_ev2", 2, 1'b1, 8'd50);
        checkEvent("t2_ev3", 3, 1'b0, 8'd50);
        checkEvent("t2_ev4", 4, 1'b1, 8'd50);
        checkEvent("t2_ev5", 5, 1'b0, 8'd50);

        // Back-pressure on the first event.
        $display("[TB] back-pressure on first event");
        setVoice0(C4, C4, C4, C4);
        loadGrid();
        evq.delete();
        n = 0;
        while (!midi_valid_out && n < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        checkOutput("t3_valid_seen", 32'(midi_valid_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_hold_valid", 32'(midi_valid_out), 32'd1);
            checkOutput("t3_hold_note", 32'(midi_note_out), 32'd48);
            checkOutput("t3_hold_status", 32'(midi_status_out), 32'd1);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("t3_no_transfer", 32'(evq.size()), 32'd0);
        checkOutput("t3_still_valid", 32'(midi_valid_out), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t3_one_transfer", 32'(evq.size()), 32'd1);
        d = 0;
        while (step_out == 2'd0 && d < 100) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            d++;
        end
        checkOutput("t3_step0_len_ok", 32'(d >= SC && d <= SC + 2*NV), 32'd1);
        stopAndDrain(50);
        checkOutput("t3_count", 32'(evq.size()), 32'd2);
        checkEvent("t3_ev0", 0, 1'b1, 8'd48);
        checkEvent("t3_ev1", 1, 1'b0, 8'd48);

        // Looping: no events across the 3->0 wrap, stop during step 2.
        $display("[TB] loop with constant 60");
        setVoice0(C5, C5, C5, C5);
        loadGrid();
        evq.delete();
        waitStep(1'b1, 2'd3, "t4_reach_step3");
        waitStep(1'b1, 2'd0, "t4_wrap_step0");
        waitStep(1'b1, 2'd2, "t4_reach_step2");
        checkOutput("t4_count_before_stop", 32'(evq.size()), 32'd1);
        stopAndDrain(50);
        checkOutput("t4_count", 32'(evq.size()), 32'd2);
        checkEvent("t4_ev0", 0, 1'b1, 8'd60);
        checkEvent("t4_ev1", 1, 1'b0, 8'd60);

        // Saturation to 127; load while busy leaves the snapshot alone.
        $display("[TB] saturation and busy load");
        setVoice0(TOP, TOP, TOP, TOP);
        loadGrid();
        evq.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        setVoice0(C4, C4, C4, C4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        stopAndDrain(50);
        runToIdle(1'b0, 200);
        checkOutput("t5_count", 32'(evq.size()), 32'd4);
        checkEvent("t5_ev0", 0, 1'b1, 8'd127);
        checkEvent("t5_ev1", 1, 1'b0, 8'd127);
        checkEvent("t5_ev2", 2, 1'b1, 8'd127);
        checkEvent("t5_ev3", 3, 1'b0, 8'd127);

        // Reset with an event pending in SCAN.
        $display("[TB] reset mid-scan");
        loadGrid();
        evq.delete();
        n = 0;
        while (!midi_valid_out && n < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        checkOutput("t6_pending", 32'(midi_valid_out), 32'd1);
        rst_in = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        rst_in = 1'b0;
        checkOutput("t6_valid", 32'(midi_valid_out), 32'd0);
        checkOutput("t6_note", 32'(midi_note_out), 32'd0);
        checkOutput("t6_vel", 32'(midi_velocity_out), 32'd0);
        checkOutput("t6_status", 32'(midi_status_out), 32'd0);
        checkOutput("t6_step", 32'(step_out), 32'd0);
        checkOutput("t6_busy", 32'(busy_out), 32'd0);
        checkOutput("t6_loaded", 32'(loaded_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_no_restart", 32'(busy_out), 32'd0);
        checkOutput("t6_no_events", 32'(evq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
